// File: rtl/timer_multi_if.sv
// Bus interface of the multi-channel timer: one read or write per clock,
// selected by we, with combinational read data and a level interrupt.
interface timer_multi_if #(
   parameter int BITS = 32
);
   // Handshake: there is no valid/ready pair. Every cycle is a bus cycle.
   // we=1 writes dataBusIn at the rising edge if memAddr decodes.
   // we=0 reads: dataBusOut is combinational, and a CNT read has its side effect at that edge.
   logic            we;
   logic [BITS-1:0] memAddr;
   logic [BITS-1:0] dataBusIn;
   logic [BITS-1:0] dataBusOut;
   logic            intr;

   modport master (output we, output memAddr, output dataBusIn,
                   input dataBusOut, input intr);
   modport slave  (input we, input memAddr, input dataBusIn,
                   output dataBusOut, output intr);
endinterface

// File: rtl/timer_multi.sv
// Multi-channel timer. A shared prescaler produces one tick every
// TIME_LENGTH clocks. Each channel counts ticks up to LIM-1, then wraps and
// raises a sticky ready flag. A second terminal event while ready is still set
// marks overrun. Registers per channel at BASE+16n: CNT(+0), LIM(+4), CTRL(+8).
module timer_multi #(
   parameter int              BITS        = 32,
   parameter logic [BITS-1:0] BASE        = 32'hF000_0100,
   parameter int              CHANNELS    = 2,
   parameter int              TIME_LENGTH = 1000
) (
   input  logic          clk,
   input  logic          reset,
   timer_multi_if.slave  bus
);
   localparam int PW = (TIME_LENGTH > 1) ? $clog2(TIME_LENGTH) : 1;

   logic [PW-1:0]         presc_q, presc_d;
   logic                  tick;

   logic [BITS-1:0]       cnt_q [CHANNELS];
   logic [BITS-1:0]       cnt_d [CHANNELS];
   logic [BITS-1:0]       lim_q [CHANNELS];
   logic [BITS-1:0]       lim_d [CHANNELS];
   logic [BITS-1:0]       ctrl_w [CHANNELS];
   logic [CHANNELS-1:0]   ready_q, ready_d, ovr_q, ovr_d;
   logic [CHANNELS-1:0]   one_q, one_d, run_q, run_d, ie_q, ie_d;

   logic [BITS-1:0]       off;
   logic [CHANNELS-1:0]   hit_cnt, hit_lim, hit_ctrl;
   logic [CHANNELS-1:0]   adv, term;

   // Shared prescaler: count 0..TIME_LENGTH-1; tick marks the last count.
   always_comb begin
      tick    = (presc_q == PW'(TIME_LENGTH - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Address decode, plus per-channel advance and terminal conditions.
   // A CNT write in the same cycle suppresses that cycle's terminal event.
   always_comb begin
      off = bus.memAddr - BASE;
      for (int n = 0; n < CHANNELS; n++) begin
         hit_cnt[n]  = (off == BITS'(16 * n));
         hit_lim[n]  = (off == BITS'(16 * n + 4));
         hit_ctrl[n] = (off == BITS'(16 * n + 8));
         adv[n]      = tick && run_q[n] && (lim_q[n] != '0);
         term[n]     = adv[n] && (cnt_q[n] == lim_q[n] - BITS'(1))
                       && !(bus.we && hit_cnt[n]);
      end
   end

   // Next-state for every channel. Bus updates are applied first.
   // The terminal event is applied last, so it wins over any ready/overrun clear.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         cnt_d[n]   = cnt_q[n];
         lim_d[n]   = lim_q[n];
         ready_d[n] = ready_q[n];
         ovr_d[n]   = ovr_q[n];
         one_d[n]   = one_q[n];
         run_d[n]   = run_q[n];
         ie_d[n]    = ie_q[n];
         if (bus.we && hit_cnt[n]) begin
            cnt_d[n] = bus.dataBusIn;
         end else if (adv[n]) begin
            cnt_d[n] = term[n] ? '0 : cnt_q[n] + BITS'(1);
         end
         if (bus.we && hit_lim[n]) begin
            lim_d[n] = bus.dataBusIn;
         end
         if (bus.we && hit_ctrl[n]) begin
            one_d[n]   = bus.dataBusIn[4];
            run_d[n]   = bus.dataBusIn[5];
            ie_d[n]    = bus.dataBusIn[8];
            ready_d[n] = ready_q[n] & bus.dataBusIn[0];
            ovr_d[n]   = ovr_q[n] & bus.dataBusIn[2];
         end
         if (!bus.we && hit_cnt[n]) begin
            ready_d[n] = 1'b0;
         end
         if (term[n]) begin
            ready_d[n] = 1'b1;
            if (ready_q[n]) ovr_d[n] = 1'b1;
            if (one_q[n])   run_d[n] = 1'b0;
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         ready_q <= '0;
         ovr_q   <= '0;
         one_q   <= '0;
         run_q   <= '0;
         ie_q    <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            cnt_q[n] <= '0;
            lim_q[n] <= '0;
         end
      end else begin
         presc_q <= presc_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
         one_q   <= one_d;
         run_q   <= run_d;
         ie_q    <= ie_d;
         for (int n = 0; n < CHANNELS; n++) begin
            cnt_q[n] <= cnt_d[n];
            lim_q[n] <= lim_d[n];
         end
      end
   end

   // Read mux and interrupt, both combinational from register state.
   always_comb begin
      bus.dataBusOut = '0;
      bus.intr       = 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
         ctrl_w[n]    = '0;
         ctrl_w[n][0] = ready_q[n];
         ctrl_w[n][2] = ovr_q[n];
         ctrl_w[n][4] = one_q[n];
         ctrl_w[n][5] = run_q[n];
         ctrl_w[n][8] = ie_q[n];
         if (!bus.we) begin
            if (hit_cnt[n])  bus.dataBusOut = cnt_q[n];
            if (hit_lim[n])  bus.dataBusOut = lim_q[n];
            if (hit_ctrl[n]) bus.dataBusOut = ctrl_w[n];
         end
         bus.intr = bus.intr | (ready_q[n] & ie_q[n]);
      end
   end
endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi. It uses 2 channels and TIME_LENGTH=4.
// A register-level model predicts the read data and intr every cycle.
// Directed sequences cover periodic, overrun, oneshot, collision, decode and reset behaviour.
module tb_timer_multi;
  localparam int          CH   = 2;
  localparam int          TL   = 4;
  localparam logic [31:0] BASE = 32'hF000_0100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  timer_multi_if #(.BITS(32)) bus ();

  timer_multi #(.BITS(32), .BASE(BASE), .CHANNELS(CH), .TIME_LENGTH(TL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done = 0;

  // model state
  logic [31:0] m_cnt [CH];
  logic [31:0] m_lim [CH];
  bit m_ready [CH];
  bit m_ovr [CH];
  bit m_one [CH];
  bit m_run [CH];
  bit m_ie [CH];
  int m_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] A(input int ch, input int r);
    return BASE + 32'(16 * ch + r);
  endfunction

  function automatic bit decode(input logic [31:0] a, output int ch, output int r);
    logic [31:0] off;
    ch = 0;
    r = 0;
    if (a < BASE) return 0;
    off = a - BASE;
    ch = int'(off / 16);
    r = int'(off % 16);
    return (ch < CH) && (r == 0 || r == 4 || r == 8);
  endfunction

  function automatic logic [31:0] ctrl_val(input int ch);
    return (32'(m_ie[ch]) << 8) | (32'(m_run[ch]) << 5) | (32'(m_one[ch]) << 4)
         | (32'(m_ovr[ch]) << 2) | 32'(m_ready[ch]);
  endfunction

  function automatic logic [31:0] exp_dout(input logic w, input logic [31:0] a);
    int ch, r;
    if (w || !decode(a, ch, r)) return 32'd0;
    if (r == 0) return m_cnt[ch];
    if (r == 4) return m_lim[ch];
    return ctrl_val(ch);
  endfunction

  function automatic logic exp_intr();
    logic v = 1'b0;
    for (int ch = 0; ch < CH; ch++) v = v | (m_ready[ch] & m_ie[ch]);
    return v;
  endfunction

  task automatic model_clear();
    m_phase = 0;
    for (int ch = 0; ch < CH; ch++) begin
      m_cnt[ch] = 0; m_lim[ch] = 0;
      m_ready[ch] = 0; m_ovr[ch] = 0; m_one[ch] = 0; m_run[ch] = 0; m_ie[ch] = 0;
    end
  endtask

  // One clock edge of the register-level model.
  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    int hc, hr;
    bit hit, tick, wc, wl, wctl, rc, counting, fires, old_ready, old_one;
    tick = (m_phase == TL - 1);
    m_phase = (m_phase + 1) % TL;
    hit = decode(a, hc, hr);
    for (int ch = 0; ch < CH; ch++) begin
      wc   = w && hit && hc == ch && hr == 0;
      wl   = w && hit && hc == ch && hr == 4;
      wctl = w && hit && hc == ch && hr == 8;
      rc   = !w && hit && hc == ch && hr == 0;
      counting = tick && m_run[ch] && m_lim[ch] != 0;
      fires = counting && !wc && (m_cnt[ch] + 32'd1 == m_lim[ch]);
      old_ready = m_ready[ch];
      old_one = m_one[ch];
      if (wc) m_cnt[ch] = d;
      else if (counting) m_cnt[ch] = fires ? 32'd0 : m_cnt[ch] + 32'd1;
      if (wl) m_lim[ch] = d;
      if (wctl) begin
        m_one[ch] = d[4]; m_run[ch] = d[5]; m_ie[ch] = d[8];
        m_ready[ch] = m_ready[ch] & d[0];
        m_ovr[ch] = m_ovr[ch] & d[2];
      end
      if (rc) m_ready[ch] = 0;
      if (fires) begin
        m_ready[ch] = 1;
        if (old_ready) m_ovr[ch] = 1;
        if (old_one) m_run[ch] = 0;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_edge(bus.we, bus.memAddr, bus.dataBusIn);
    end
  end

  // scoreboard compare every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !done) begin
        check("dout", bus.dataBusOut, exp_dout(bus.we, bus.memAddr));
        check("intr", 32'(bus.intr), 32'(exp_intr()));
      end
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.we = w; bus.memAddr = a; bus.dataBusIn = d;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.we = 1'b0; bus.memAddr = a; bus.dataBusIn = 32'd0;
    @(negedge clk);
    v = bus.dataBusOut;
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the cycle whose closing edge is a prescaler tick.
  task automatic wait_tick_next();
    int g = 0;
    while (m_phase != TL - 1 && g < 2 * TL) begin
      idle(1);
      g++;
    end
    if (m_phase != TL - 1) begin
      checks++;
      failures++;
      $display("FAIL tick_align phase=%0d required=%0d", m_phase, TL - 1);
    end
  endtask

  logic [31:0] v;

  initial begin
    bus.we = 1'b0; bus.memAddr = 32'd0; bus.dataBusIn = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.memAddr = A(0, 8);
    #1;
    check("rst_dout", bus.dataBusOut, 32'd0);
    check("rst_intr", 32'(bus.intr), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd(A(0, 8), v); check("rst_ctrl", v, 32'd0);

    // periodic channel 0
    wr(A(0, 4), 32'd3);
    wr(A(0, 8), 32'h120);
    idle(12);
    check("per_intr", 32'(bus.intr), 32'd1);
    rd(A(0, 0), v); check("per_cnt", v, 32'd0);
    check("per_intr_clr", 32'(bus.intr), 32'd0);
    rd(A(0, 8), v); check("per_ctrl", v, 32'h120);
    idle(24);
    wr(A(0, 8), 32'h0);

    // overrun channel 1
    wr(A(1, 4), 32'd2);
    wr(A(1, 8), 32'h020);
    idle(16);
    rd(A(1, 8), v); check("ovr_ctrl", v, 32'h025);
    wr(A(1, 8), 32'h020);
    rd(A(1, 8), v); check("ovr_clr", v, 32'h020);
    wr(A(1, 8), 32'h0);

    // oneshot channel 0
    wr(A(0, 0), 32'd0);
    wr(A(0, 4), 32'd5);
    wr(A(0, 8), 32'h030);
    idle(20);
    rd(A(0, 8), v); check("one_ctrl", v, 32'h011);
    idle(100);
    rd(A(0, 0), v); check("one_cnt", v, 32'd0);

    // collisions
    wr(A(0, 8), 32'h020);
    wr(A(0, 4), 32'd10);
    wr(A(0, 0), 32'd0);
    wait_tick_next();
    wr(A(0, 0), 32'd7);
    rd(A(0, 0), v); check("col_wr", v, 32'd7);
    wr(A(0, 0), 32'd9);
    wait_tick_next();
    rd(A(0, 0), v); check("col_rd_val", v, 32'd9);
    rd(A(0, 8), v); check("col_ready", v, 32'h021);
    wr(A(0, 4), 32'd0);
    wr(A(0, 0), 32'd5);
    idle(12);
    rd(A(0, 0), v); check("col_freeze", v, 32'd5);
    wr(A(0, 8), 32'h0);

    // decode
    wr(A(0, 4), 32'd5);
    rd(BASE + 32'd4, v); check("dec_lim", v, 32'd5);
    rd(BASE + 32'd12, v); check("dec_gap", v, 32'd0);
    rd(BASE + 32'd32, v); check("dec_out", v, 32'd0);
    wr(BASE + 32'd12, 32'hFFFF_FFFF);
    wr(A(1, 0), 32'h66);
    wr(A(1, 4), 32'h55);
    wr(A(1, 8), 32'h100);
    rd(A(0, 0), v); check("dec_ch0_cnt", v, 32'd5);
    rd(A(0, 8), v); check("dec_ch0_ctrl", v, 32'd0);
    rd(A(1, 4), v); check("dec_ch1_lim", v, 32'h55);
    wr(A(1, 8), 32'h0);

    // reset mid-count
    wr(A(0, 4), 32'd10);
    wr(A(0, 8), 32'h120);
    wr(A(0, 0), 32'd9);
    wait_tick_next(); idle(1);
    wait_tick_next(); idle(1);
    wait_tick_next(); idle(1);
    rd(A(0, 8), v); check("rm_ctrl", v, 32'h121);
    check("rm_intr_pre", 32'(bus.intr), 32'd1);
    bus.we = 1'b0; bus.memAddr = A(0, 0);
    #2 reset = 1'b1;
    #1;
    check("rm_dout", bus.dataBusOut, 32'd0);
    check("rm_intr", 32'(bus.intr), 32'd0);
    bus.we = 1'b1; bus.memAddr = A(0, 4); bus.dataBusIn = 32'd77;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(20);
    rd(A(0, 0), v); check("rm_cnt", v, 32'd0);
    rd(A(0, 4), v); check("rm_lim", v, 32'd0);
    rd(A(0, 8), v); check("rm_ctrl0", v, 32'd0);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 Parameter BITS, 32, bus data/address width and counter width.
REQ-002 Parameter BASE, 32'hF000_0100, byte address of channel 0 CNT register.
REQ-003 Parameter CHANNELS, 2, number of independent timer channels, legal range 1..4.
REQ-004 Parameter TIME_LENGTH, 1000, clk cycles per shared prescaler tick, legal range >=1.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 we  input  1  1 = bus write into device this cycle; 0 = bus read.
REQ-008 memAddr  input  BITS  bus byte address.
REQ-009 dataBusIn  input  BITS  write data.
REQ-010 dataBusOut  output  BITS  combinational read data.
REQ-011 intr  output  1  interrupt request, level, registered-state derived.

Function
REQ-012 Channel n registers SHALL decode at BASE+16n: +0 CNT, +4 LIM, +8 CTRL; any other address SHALL not match.
REQ-013 CTRL fields SHALL be: bit0 ready (sticky), bit2 overrun (sticky), bit4 oneshot, bit5 run, bit8 ie; all other bits read 0.
REQ-014 A shared prescaler SHALL count 0..TIME_LENGTH-1 and wrap to 0; tick is asserted during the cycle its value equals TIME_LENGTH-1.
REQ-015 On tick with run=1 and LIM!=0, a channel SHALL increment CNT, or, if CNT==LIM-1 (terminal), load CNT=0 and raise a terminal event.
REQ-016 Terminal event SHALL set ready=1; SHALL set overrun=1 if ready was already 1; in oneshot=1 SHALL clear run.
REQ-017 LIM==0 or run==0 SHALL freeze CNT and suppress terminal events; CNT>=LIM (after LIM shrink) SHALL keep incrementing with BITS-bit wrap until CNT==LIM-1.
REQ-018 Bus write to CNT SHALL load dataBusIn and take priority over the same-cycle tick update; no terminal event that cycle.
REQ-019 Bus write to LIM SHALL load dataBusIn at that edge; the new value applies from the next cycle.
REQ-020 Bus write to CTRL SHALL load oneshot, run, ie; ready and overrun SHALL clear where the written bit is 0 and be unchanged where 1.
REQ-021 Bus read of CNT (we=0, address match) SHALL clear that channel's ready at the clock edge.
REQ-022 A same-cycle terminal event SHALL win over any ready/overrun clear (read or CTRL write).
REQ-023 dataBusOut SHALL return the addressed CNT, LIM or CTRL (pre-edge value) when we=0 and an address matches, else all zeros.
REQ-024 intr SHALL equal OR over channels of (ready & ie), combinational from register state.
REQ-025 Channels SHALL be fully independent except for the shared prescaler tick.

Reset
REQ-026 reset=1 SHALL asynchronously clear prescaler, all CNT, LIM, CTRL to 0; intr=0; dataBusOut depends only on bus inputs.
REQ-027 Reset asserted mid-count SHALL abandon the count; after release the prescaler restarts at 0 and all channels are stopped.
REQ-028 No state SHALL change while reset is high, including bus writes.

Verification (BITS=32, CHANNELS=2, TIME_LENGTH=4, BASE=32'hF000_0100)
REQ-029 Periodic: ch0 LIM=3, CTRL=0x120 -> ready rises, CNT 0 after every 12 clks, intr=1 after first terminal; read CNT -> ready=0, intr=0.
REQ-030 Overrun: ch1 LIM=2, CTRL=0x020, no reads -> second terminal sets CTRL=0x025; write CTRL=0x020 -> reads 0x020.
REQ-031 Oneshot: ch0 LIM=5, CTRL=0x030 -> one terminal, CTRL reads 0x011, CNT holds 0 for 100 further clks.
REQ-032 Collisions: CNT write 7 on tick -> CNT=7; CNT read on terminal tick -> ready remains 1; LIM=0 -> CNT frozen.
REQ-033 Decode: read BASE+4 returns LIM, BASE+12 and BASE+32 return 0; ch1 writes leave ch0 unchanged.
REQ-034 Reset mid-count: assert reset with CNT=2, ready=1 -> all registers 0 immediately, intr=0, no counting after release until run written.
